execute_mc: RTL and testbench
=============================

# execute_mc

Parametrised execute stage for the pipelined ARM-subset core. It sits between the ID/EX and EX/MEM pipeline registers. It provides:
- WIDTH-bit operand forwarding from the writeback and memory stages.
- A WIDTH-bit ALU and condition evaluation against an internal NZCV register.
- An iterative shift-add multiplier that stalls the front of the pipeline while it runs.

## Interface
Parameters:
- WIDTH, 32, datapath width (≥ 8)
- CNT_W, $clog2(WIDTH+1), multiplier counter width

Ports:
- CLK  in  1  clock; one clock domain, rising edge
- RESET  in  1  synchronous, active-high reset
- FlushE  in  1  cancel the instruction in execute (including a running multiply)
- ValidE  in  1  the ID/EX register holds a real instruction
- PCSrcE, RegWriteE, MemWriteE, BranchE, NoWrite, ALUSrcE, MulE  in  1 each  decoded controls
- FlagWriteE  in  2  bit1 updates N,Z; bit0 updates C,V
- ForwardAE, ForwardBE  in  2  00 RD, 01 ResultW, 10 ALUResultM, 11 treated as 00
- ALUControlE  in  4  ALU op
- CondE  in  4  ARM condition field
- RD1E, RD2E, ExtImmE, ResultW, ALUResultM  in  WIDTH  operands and forwarded values
- ALUResultE, WriteDataE  out  WIDTH  result; forwarded RD2 for stores
- FlagsOut  out  4  NZCV register {N,Z,C,V}
- PCSrcEOut, RegWriteEOut, MemWriteEOut, BranchEOut  out  1  condition-gated controls
- StallE  out  1  freezes fetch, decode and ID/EX while the multiply runs; bubbles EX/MEM

## Operation
- SrcA = forward mux A. SrcB = ALUSrcE ? ExtImmE : forward mux B. WriteDataE = forward mux B.
- ALU ops:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 ORR, 4 EOR, 5 MOV (B), 6 BIC, 7 MVN, 8 RSB (B−A).
  - 9–15 produce result 0 with C=V=0.
  - Arithmetic uses WIDTH+1-bit sums. C = carry-out; for subtracts C = NOT borrow. V = signed overflow.
  - Logical ops set C=V=0.
  - N = result[WIDTH−1]; Z = (result==0).
- Condition check CondEx uses the registered FlagsOut with the full ARM table (0000 EQ … 1101 LE, 1110 AL). 1111 is never true.
- Gating: Go = ValidE & CondEx & ~FlushE.
  - RegWriteEOut = Go & RegWriteE & ~NoWrite.
  - MemWriteEOut = Go & MemWriteE.
  - PCSrcEOut = Go & PCSrcE.
  - BranchEOut = Go & BranchE.
- Flag update at the clock edge when Go and the op is not a multiply issue:
  - N,Z load from the ALU when FlagWriteE[1] is set.
  - C,V load from the ALU when FlagWriteE[0] is set.
- Multiplier FSM has three states: IDLE, BUSY, DONE.
  - **IDLE**: When Go & MulE, latch SrcA, SrcB, the control bits and FlagWriteE[1]; clear the accumulator; set cnt=WIDTH; go to BUSY. In the issue cycle StallE=1 and all gated outputs are 0. If Go is false, a MulE instruction is dropped and no stall occurs.
  - **BUSY**: Each cycle, if multiplier bit 0 is set, acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt−−. When cnt reaches 1, go to DONE. StallE=1 and gated outputs are 0.
  - **DONE**: StallE=0. ALUResultE = acc[WIDTH−1:0], the low half of the product. RegWriteEOut = the latched RegWriteE & ~NoWrite. If the latched FlagWrite[1] is set, N,Z load from acc; C,V are unchanged. Then go to IDLE. The pipeline, unfrozen, advances past the multiply on this edge.
- FlushE in BUSY or DONE returns the FSM to IDLE at the next edge with no register write and no flag change.

## Timing
- Non-multiply instructions: combinational from inputs to ALUResultE and the gated controls; 0-cycle latency. Flags are visible the next cycle.
- Multiply issued at cycle t:
  - StallE is high from t through t+WIDTH.
  - The result is valid in cycle t+WIDTH+1 (DONE). Total occupancy is WIDTH+2 cycles.
- RESET:
  - At the edge: FSM goes to IDLE, FlagsOut=0000, and the accumulator clears.
  - While RESET is high: StallE=0 and all gated outputs are 0.
  - RESET mid-multiply abandons it.
- RESET takes priority over FlushE, which takes priority over an issue or advance.
- Simultaneous issue and FlushE: no issue.
- Back-to-back multiplies: a DONE cycle may be followed directly by a new issue in IDLE.

## Configuration
- EXECUTE_MC_MUL_EN defined: the multiplier FSM is built as described.
- Not defined: the FSM is removed and StallE is tied to 0. MulE is ignored and the instruction executes as its ALUControlE op. Area is the ALU only.

## Test plan
- WIDTH=32, ADD, RD1E=0x7FFFFFFF, RD2E=1, FlagWriteE=11, CondE=1110 → ALUResultE=0x80000000; next cycle FlagsOut=1001 (N,V).
- SUB 5−5 with FlagWriteE=11, then a BEQ with BranchE=PCSrcE=1, CondE=0000 → FlagsOut=0110, PCSrcEOut=1. The same branch with CondE=0001 gives PCSrcEOut=0.
- ForwardAE=10, ALUResultM=0x10, RD1E=0x99, ADD with immediate 4 (ALUSrcE=1) → ALUResultE=0x14. With ForwardBE=01, WriteDataE=ResultW.
- MUL 0x0000FFFF × 0x00010001 issued at t → StallE=1 for t..t+32. At t+33: ALUResultE=0xFFFFFFFF, RegWriteEOut=1, StallE=0.
- RESET pulsed at t+10 during a multiply → StallE=0, FlagsOut=0000, RegWriteEOut stays 0; a following ADD executes normally.
- FlushE at t+5 of a multiply → IDLE at t+6, no RegWriteEOut, flags unchanged. With EXECUTE_MC_MUL_EN undefined, MulE=1 never raises StallE.

Source files
------------

// File: rtl/execute_mc_if.sv
// Execute-stage bundle: ID/EX controls and operands in, condition-gated results and stall out.
interface execute_mc_if #(
   parameter int unsigned WIDTH = 32
);
   logic             FlushE;
   logic             ValidE;
   logic             PCSrcE;
   logic             RegWriteE;
   logic             MemWriteE;
   logic             BranchE;
   logic             NoWrite;
   logic             ALUSrcE;
   logic             MulE;
   logic [1:0]       FlagWriteE;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic [3:0]       ALUControlE;
   logic [3:0]       CondE;
   logic [WIDTH-1:0] RD1E;
   logic [WIDTH-1:0] RD2E;
   logic [WIDTH-1:0] ExtImmE;
   logic [WIDTH-1:0] ResultW;
   logic [WIDTH-1:0] ALUResultM;
   logic [WIDTH-1:0] ALUResultE;
   logic [WIDTH-1:0] WriteDataE;
   logic [3:0]       FlagsOut;
   logic             PCSrcEOut;
   logic             RegWriteEOut;
   logic             MemWriteEOut;
   logic             BranchEOut;
   logic             StallE;

   modport master (
      output FlushE, ValidE, PCSrcE, RegWriteE, MemWriteE, BranchE, NoWrite, ALUSrcE, MulE,
             FlagWriteE, ForwardAE, ForwardBE, ALUControlE, CondE,
             RD1E, RD2E, ExtImmE, ResultW, ALUResultM,
      input  ALUResultE, WriteDataE, FlagsOut, PCSrcEOut, RegWriteEOut, MemWriteEOut,
             BranchEOut, StallE
   );

   modport slave (
      input  FlushE, ValidE, PCSrcE, RegWriteE, MemWriteE, BranchE, NoWrite, ALUSrcE, MulE,
             FlagWriteE, ForwardAE, ForwardBE, ALUControlE, CondE,
             RD1E, RD2E, ExtImmE, ResultW, ALUResultM,
      output ALUResultE, WriteDataE, FlagsOut, PCSrcEOut, RegWriteEOut, MemWriteEOut,
             BranchEOut, StallE
   );
endinterface

// File: rtl/execute_mc.sv
// Execute stage: forwarding, ALU, NZCV condition gating and an optional iterative multiplier.
// Define EXECUTE_MC_MUL_EN to build the shift-add multiplier FSM; otherwise StallE is tied low.
module execute_mc #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input logic          CLK,
   input logic          RESET,
   execute_mc_if.slave  ex
);

   localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] srca, srcb, fwdb;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [3:0]       flags_q, flags_d;
   logic             condex, go, alu_upd;
   logic             mul_stall, mul_done, mul_rw, mul_fw;
   logic [WIDTH-1:0] mul_res;

   always_comb begin
      case (ex.ForwardAE)
         2'b01:   srca = ex.ResultW;
         2'b10:   srca = ex.ALUResultM;
         default: srca = ex.RD1E;
      endcase
      case (ex.ForwardBE)
         2'b01:   fwdb = ex.ResultW;
         2'b10:   fwdb = ex.ALUResultM;
         default: fwdb = ex.RD2E;
      endcase
      srcb = ex.ALUSrcE ? ex.ExtImmE : fwdb;
   end

   // Subtracts are formed as x + ~y + 1 so the carry-out is already NOT borrow.
   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ex.ALUControlE)
         4'd0: begin
            sum     = {1'b0, srca} + {1'b0, srcb};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (srca[WIDTH-1] == srcb[WIDTH-1]) & (alu_res[WIDTH-1] != srca[WIDTH-1]);
         end
         4'd1: begin
            sum     = {1'b0, srca} + {1'b0, ~srcb} + One;
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (srca[WIDTH-1] != srcb[WIDTH-1]) & (alu_res[WIDTH-1] != srca[WIDTH-1]);
         end
         4'd2: alu_res = srca & srcb;
         4'd3: alu_res = srca | srcb;
         4'd4: alu_res = srca ^ srcb;
         4'd5: alu_res = srcb;
         4'd6: alu_res = srca & ~srcb;
         4'd7: alu_res = ~srcb;
         4'd8: begin
            sum     = {1'b0, srcb} + {1'b0, ~srca} + One;
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (srcb[WIDTH-1] != srca[WIDTH-1]) & (alu_res[WIDTH-1] != srcb[WIDTH-1]);
         end
         default: ;
      endcase
   end

   always_comb begin
      case (ex.CondE)
         4'h0:    condex = flags_q[2];
         4'h1:    condex = ~flags_q[2];
         4'h2:    condex = flags_q[1];
         4'h3:    condex = ~flags_q[1];
         4'h4:    condex = flags_q[3];
         4'h5:    condex = ~flags_q[3];
         4'h6:    condex = flags_q[0];
         4'h7:    condex = ~flags_q[0];
         4'h8:    condex = flags_q[1] & ~flags_q[2];
         4'h9:    condex = ~flags_q[1] | flags_q[2];
         4'ha:    condex = flags_q[3] == flags_q[0];
         4'hb:    condex = flags_q[3] != flags_q[0];
         4'hc:    condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
         4'hd:    condex = flags_q[2] | (flags_q[3] != flags_q[0]);
         4'he:    condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   assign go = ex.ValidE & condex & ~ex.FlushE & ~RESET;

`ifdef EXECUTE_MC_MUL_EN
   typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rw_q, rw_d, fw_q, fw_d;
   logic             mul_issue;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         rw_q     <= 1'b0;
         fw_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         rw_q     <= rw_d;
         fw_q     <= fw_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      fw_d      = fw_q;
      mul_issue = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go && ex.MulE) begin
               mul_issue = 1'b1;
               mcand_d   = srca;
               mplier_d  = srcb;
               acc_d     = '0;
               cnt_d     = CNT_W'(WIDTH);
               rw_d      = ex.RegWriteE & ~ex.NoWrite;
               fw_d      = ex.FlagWriteE[1];
               state_d   = StBusy;
            end
         end
         StBusy: begin
            if (ex.FlushE) begin
               state_d = StIdle;
            end else begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign mul_stall = ((state_q == StBusy) & ~RESET) | mul_issue;
   assign mul_done  = (state_q == StDone);
   assign mul_res   = acc_q;
   assign mul_rw    = rw_q;
   assign mul_fw    = fw_q;
   assign alu_upd   = go & ~ex.MulE & (state_q == StIdle);
`else
   logic unused_mul;

   assign unused_mul = ex.MulE;
   assign mul_stall  = 1'b0;
   assign mul_done   = 1'b0;
   assign mul_res    = '0;
   assign mul_rw     = 1'b0;
   assign mul_fw     = 1'b0;
   assign alu_upd    = go;
`endif

   always_comb begin
      flags_d = flags_q;
      if (alu_upd) begin
         if (ex.FlagWriteE[1]) flags_d[3:2] = {alu_res[WIDTH-1], alu_res == '0};
         if (ex.FlagWriteE[0]) flags_d[1:0] = {alu_c, alu_v};
      end
      if (mul_done && mul_fw && !ex.FlushE) flags_d[3:2] = {mul_res[WIDTH-1], mul_res == '0};
   end

   always_ff @(posedge CLK) begin
      if (RESET) flags_q <= 4'b0000;
      else       flags_q <= flags_d;
   end

   always_comb begin
      ex.ALUResultE   = alu_res;
      ex.WriteDataE   = fwdb;
      ex.FlagsOut     = flags_q;
      ex.RegWriteEOut = go & ex.RegWriteE & ~ex.NoWrite;
      ex.MemWriteEOut = go & ex.MemWriteE;
      ex.PCSrcEOut    = go & ex.PCSrcE;
      ex.BranchEOut   = go & ex.BranchE;
      ex.StallE       = 1'b0;
      if (mul_stall) begin
         ex.StallE       = 1'b1;
         ex.RegWriteEOut = 1'b0;
         ex.MemWriteEOut = 1'b0;
         ex.PCSrcEOut    = 1'b0;
         ex.BranchEOut   = 1'b0;
      end else if (mul_done) begin
         // ID/EX still holds the multiply here, so only its latched write is released.
         ex.ALUResultE   = mul_res;
         ex.RegWriteEOut = mul_rw & ~ex.FlushE & ~RESET;
         ex.MemWriteEOut = 1'b0;
         ex.PCSrcEOut    = 1'b0;
         ex.BranchEOut   = 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: directed vectors, per-cycle comparison against a behavioural model.
module tb_execute_mc;
   localparam int unsigned W = 32;
`ifdef EXECUTE_MC_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif
   localparam longint SMax = 64'sd2147483647;
   localparam longint SMin = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   execute_mc_if #(.WIDTH(W)) bus ();
   execute_mc #(.WIDTH(W)) dut (.CLK(clk), .RESET(rst), .ex(bus.slave));

   always #5 clk = ~clk;

   logic [31:0] op_a [4] = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
   logic [31:0] op_b [4] = '{32'd5, 32'h8000_0000, 32'h0000_0001, 32'h0F0F_0F0F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                       input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'b01) return w;
      if (sel == 2'b10) return m;
      return rd;
   endfunction

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'ha: return n == v;
         4'hb: return n != v;
         4'hc: return !z && (n == v);
         4'hd: return z || (n != v);
         4'he: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Flags derived from true-width arithmetic rather than from carry chains.
   task automatic model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic c, output logic v);
      longint sa, sb, sr;
      sa = $signed(a);
      sb = $signed(b);
      sr = 0;
      r = '0;
      c = 1'b0;
      case (op)
         4'd0: begin r = a + b; c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; sr = sa + sb; end
         4'd1: begin r = a - b; c = a >= b; sr = sa - sb; end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = b;
         4'd6: r = a & ~b;
         4'd7: r = ~b;
         4'd8: begin r = b - a; c = b >= a; sr = sb - sa; end
         default: ;
      endcase
      v = (sr > SMax) || (sr < SMin);
   endtask

   // Model state: flags, and multiply age (0 = none, 1..W busy, W+1 result cycle).
   logic [3:0]      m_flags = 4'b0000;
   int              m_age = 0;
   logic [31:0]     m_prod = '0;
   logic            m_rw = 1'b0, m_fw = 1'b0;
   logic [31:0]     e_a, e_wd, e_b, e_r;
   logic            e_c, e_v, e_go;
   logic [3:0]      e_nf;
   longint unsigned e_p64;

   always @(negedge clk) begin
      e_a  = fwd(bus.ForwardAE, bus.RD1E, bus.ResultW, bus.ALUResultM);
      e_wd = fwd(bus.ForwardBE, bus.RD2E, bus.ResultW, bus.ALUResultM);
      e_b  = bus.ALUSrcE ? bus.ExtImmE : e_wd;
      model_alu(bus.ALUControlE, e_a, e_b, e_r, e_c, e_v);
      e_go = bus.ValidE && cond_ok(bus.CondE, m_flags) && !bus.FlushE && !rst;
      e_nf = m_flags;
      chk("flags", {28'b0, bus.FlagsOut}, {28'b0, m_flags});
      chk("wdata", bus.WriteDataE, e_wd);
      if (rst) begin
         chkb("rst_stall", bus.StallE, 1'b0);
         chkb("rst_rw", bus.RegWriteEOut, 1'b0);
         chkb("rst_mw", bus.MemWriteEOut, 1'b0);
         chkb("rst_pc", bus.PCSrcEOut, 1'b0);
         chkb("rst_br", bus.BranchEOut, 1'b0);
         e_nf  = 4'b0000;
         m_age = 0;
      end else if (m_age != 0 && m_age <= W) begin
         chkb("busy_stall", bus.StallE, 1'b1);
         chkb("busy_rw", bus.RegWriteEOut, 1'b0);
         chkb("busy_mw", bus.MemWriteEOut, 1'b0);
         chkb("busy_pc", bus.PCSrcEOut, 1'b0);
         chkb("busy_br", bus.BranchEOut, 1'b0);
         m_age = bus.FlushE ? 0 : m_age + 1;
      end else if (m_age == W + 1) begin
         chkb("done_stall", bus.StallE, 1'b0);
         chk("done_res", bus.ALUResultE, m_prod);
         chkb("done_rw", bus.RegWriteEOut, m_rw && !bus.FlushE);
         chkb("done_mw", bus.MemWriteEOut, 1'b0);
         chkb("done_pc", bus.PCSrcEOut, 1'b0);
         if (!bus.FlushE && m_fw) e_nf[3:2] = {m_prod[31], m_prod == 32'd0};
         m_age = 0;
      end else if (MulEn && e_go && bus.MulE) begin
         chkb("issue_stall", bus.StallE, 1'b1);
         chkb("issue_rw", bus.RegWriteEOut, 1'b0);
         chkb("issue_mw", bus.MemWriteEOut, 1'b0);
         chkb("issue_pc", bus.PCSrcEOut, 1'b0);
         e_p64  = 64'(e_a) * 64'(e_b);
         m_prod = e_p64[31:0];
         m_rw   = bus.RegWriteE && !bus.NoWrite;
         m_fw   = bus.FlagWriteE[1];
         m_age  = 1;
      end else begin
         chkb("stall", bus.StallE, 1'b0);
         chk("alu_res", bus.ALUResultE, e_r);
         chkb("rw", bus.RegWriteEOut, e_go && bus.RegWriteE && !bus.NoWrite);
         chkb("mw", bus.MemWriteEOut, e_go && bus.MemWriteE);
         chkb("pc", bus.PCSrcEOut, e_go && bus.PCSrcE);
         chkb("br", bus.BranchEOut, e_go && bus.BranchE);
         if (e_go && bus.FlagWriteE[1]) e_nf[3:2] = {e_r[31], e_r == 32'd0};
         if (e_go && bus.FlagWriteE[0]) e_nf[1:0] = {e_c, e_v};
      end
      m_flags = e_nf;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.FlushE = 0; bus.ValidE = 0; bus.PCSrcE = 0; bus.RegWriteE = 0; bus.MemWriteE = 0;
      bus.BranchE = 0; bus.NoWrite = 0; bus.ALUSrcE = 0; bus.MulE = 0;
      bus.FlagWriteE = 2'b00; bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b00;
      bus.ALUControlE = 4'd0; bus.CondE = 4'he;
      bus.RD1E = '0; bus.RD2E = '0; bus.ExtImmE = '0; bus.ResultW = '0; bus.ALUResultM = '0;
   endtask

   task automatic alu_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] fw, input logic [3:0] cond);
      idle_in();
      bus.ValidE = 1; bus.RegWriteE = 1; bus.ALUControlE = op;
      bus.RD1E = a; bus.RD2E = b; bus.FlagWriteE = fw; bus.CondE = cond;
   endtask

   // Drives a multiply and holds it, as a frozen ID/EX would, until the result cycle.
   task automatic mul_in(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fw);
      alu_in(4'd0, a, b, fw, 4'he);
      bus.MulE = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle_in();
      bus.ValidE = 1; bus.RegWriteE = 1;
      @(negedge clk);
      chkb("lit_reset_rw", bus.RegWriteEOut, 1'b0);
      tick();
      rst = 0;
      alu_in(4'd0, 32'h7FFF_FFFF, 32'd1, 2'b11, 4'he);
      @(negedge clk);
      chk("lit_add_res", bus.ALUResultE, 32'h8000_0000);
      tick(); idle_in();
      @(negedge clk);
      chk("lit_add_flags", {28'b0, bus.FlagsOut}, 32'h9);

      tick(); alu_in(4'd1, 32'd5, 32'd5, 2'b11, 4'he);
      tick(); alu_in(4'd0, 32'd0, 32'd0, 2'b00, 4'h0);
      bus.RegWriteE = 0; bus.BranchE = 1; bus.PCSrcE = 1;
      @(negedge clk);
      chk("lit_sub_flags", {28'b0, bus.FlagsOut}, 32'h6);
      chkb("lit_beq_taken", bus.PCSrcEOut, 1'b1);
      tick(); bus.CondE = 4'h1;
      @(negedge clk);
      chkb("lit_bne_not", bus.PCSrcEOut, 1'b0);

      tick(); alu_in(4'd0, 32'h99, 32'h55, 2'b00, 4'he);
      bus.ForwardAE = 2'b10; bus.ALUResultM = 32'h10; bus.ALUSrcE = 1; bus.ExtImmE = 32'd4;
      bus.ForwardBE = 2'b01; bus.ResultW = 32'hCAFE;
      @(negedge clk);
      chk("lit_fwd_res", bus.ALUResultE, 32'h14);
      chk("lit_fwd_wdata", bus.WriteDataE, 32'hCAFE);
      tick(); bus.ForwardAE = 2'b11;
      @(negedge clk);
      chk("lit_fwd11_res", bus.ALUResultE, 32'h9D);

      for (int i = 0; i < 64; i++) begin
         tick(); idle_in();
         bus.ALUControlE = 4'(i % 16);
         bus.RD1E = op_a[i / 16]; bus.RD2E = op_b[i / 16];
         bus.ResultW = 32'h0000_0A00 + 32'(i); bus.ALUResultM = 32'hF000_0000 - 32'(i);
         bus.ForwardAE = 2'(i % 4); bus.ForwardBE = 2'((i / 4) % 4);
         bus.ALUSrcE = (i % 5 == 3); bus.ExtImmE = 32'h0000_0100;
         bus.FlagWriteE = 2'((i / 2) % 4); bus.CondE = 4'((i * 7) % 16);
         bus.ValidE = (i % 7 != 6); bus.RegWriteE = 1; bus.NoWrite = (i % 5 == 0);
         bus.MemWriteE = (i % 2 == 1); bus.BranchE = (i % 3 == 0); bus.PCSrcE = (i % 3 == 1);
      end

      tick(); mul_in(32'h0000_FFFF, 32'h0001_0001, 2'b10);
      @(negedge clk);
      chkb("lit_mul_issue_stall", bus.StallE, MulEn);
      repeat (W) tick();
      @(negedge clk);
      chkb("lit_mul_last_stall", bus.StallE, MulEn);
      tick();
      @(negedge clk);
      chk("lit_mul_res", bus.ALUResultE, MulEn ? 32'hFFFF_FFFF : 32'h0002_0000);
      chkb("lit_mul_rw", bus.RegWriteEOut, 1'b1);
      chkb("lit_mul_done_stall", bus.StallE, 1'b0);

      tick(); mul_in(32'd7, 32'd9, 2'b10);
      bus.CondE = 4'hf;
      tick(); mul_in(32'd3, 32'd5, 2'b10);
      repeat (10) tick();
      rst = 1;
      @(negedge clk);
      chkb("lit_rst_mid_stall", bus.StallE, 1'b0);
      chkb("lit_rst_mid_rw", bus.RegWriteEOut, 1'b0);
      tick(); rst = 0;
      alu_in(4'd0, 32'd2, 32'd3, 2'b00, 4'he);
      @(negedge clk);
      chk("lit_rst_flags", {28'b0, bus.FlagsOut}, 32'h0);
      chk("lit_rst_add", bus.ALUResultE, 32'd5);

      tick(); mul_in(32'h0000_1234, 32'd16, 2'b11);
      repeat (5) tick();
      bus.FlushE = 1;
      tick(); idle_in();
      @(negedge clk);
      chkb("lit_flush_stall", bus.StallE, 1'b0);
      chkb("lit_flush_rw", bus.RegWriteEOut, 1'b0);
      repeat (2) tick();

      tick(); mul_in(32'd3, 32'd5, 2'b10);
      repeat (W + 1) tick();
      tick(); mul_in(32'hFFFF_FFFF, 32'd2, 2'b10);
      bus.NoWrite = 1;
      repeat (W + 1) tick();
      tick(); idle_in();
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
